// File: rtl/busca_instrucao.sv
// Instruction fetch unit: owns the PC, addresses the ROM and presents fetched words over valid/ready.
// Define CONTADOR_BUSCA_EN to add the saturating handshake counter output total_buscas.
`timescale 1ns/1ps
module busca_instrucao #(
    parameter int unsigned TAM_MEM     = 32,
    parameter int unsigned LARG        = 8,
    parameter int unsigned END_INICIAL = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            iniciar,
    input  logic            parar,
    input  logic            desvio_en,
    input  logic [LARG-1:0] desvio_endereco,
    output logic [LARG-1:0] ler_endereco,
    input  logic [LARG-1:0] instrucao_in,
    output logic [LARG-1:0] instrucao_out,
    output logic [LARG-1:0] pc_out,
    output logic            valido,
    input  logic            pronto,
    output logic            ocupado
`ifdef CONTADOR_BUSCA_EN
    ,
    output logic [15:0]     total_buscas
`endif
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        PARADO = 2'd2
    } estado_t;

    localparam logic [LARG-1:0] ULTIMO   = LARG'(TAM_MEM - 1);
    localparam logic [LARG-1:0] PC_RESET = LARG'(END_INICIAL);

    estado_t         estado, estado_prox;
    logic [LARG-1:0] pc, pc_prox;
    logic [LARG-1:0] instrucao_prox, pc_out_prox;
    logic            valido_prox;
    logic            carrega;
    logic [LARG-1:0] alvo;
    logic [LARG-1:0] pc_seguinte;

    assign ler_endereco = pc;

    // Out-of-range branch targets fall back to address 0
    assign alvo        = (32'(desvio_endereco) < TAM_MEM) ? desvio_endereco : '0;
    assign pc_seguinte = (pc == ULTIMO) ? '0 : pc + LARG'(1);

    always_comb begin
        estado_prox    = estado;
        pc_prox        = pc;
        instrucao_prox = instrucao_out;
        pc_out_prox    = pc_out;
        valido_prox    = valido;
        carrega        = !valido || pronto;

        if (desvio_en) begin
            // Branch flushes the output stage; state is kept
            pc_prox     = alvo;
            valido_prox = 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) estado_prox = BUSCA;
                end
                BUSCA: begin
                    if (parar) begin
                        estado_prox = PARADO;
                        if (pronto) valido_prox = 1'b0;
                    end else if (carrega) begin
                        instrucao_prox = instrucao_in;
                        pc_out_prox    = pc;
                        valido_prox    = 1'b1;
                        pc_prox        = pc_seguinte;
                    end
                end
                PARADO: begin
                    // Drain any pending word, then wait for a resume
                    if (pronto) valido_prox = 1'b0;
                    if (iniciar && !parar) estado_prox = BUSCA;
                end
                default: estado_prox = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado        <= OCIOSO;
            pc            <= PC_RESET;
            instrucao_out <= '0;
            pc_out        <= '0;
            valido        <= 1'b0;
            ocupado       <= 1'b0;
        end else begin
            estado        <= estado_prox;
            pc            <= pc_prox;
            instrucao_out <= instrucao_prox;
            pc_out        <= pc_out_prox;
            valido        <= valido_prox;
            ocupado       <= (estado_prox != OCIOSO);
        end
    end

`ifdef CONTADOR_BUSCA_EN
    // Completed handshakes, saturating; a branch does not clear it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_buscas <= '0;
        end else if (valido && pronto && (total_buscas != 16'hFFFF)) begin
            total_buscas <= total_buscas + 16'd1;
        end
    end
`endif

endmodule
